// File: rtl/ysyx_23060332_dmem_resp.sv
// Data-memory responder: word SRAM model behind a one-at-a-time req_ready/rsp_valid handshake.
// Optional YSYX_23060332_DMEM_RANGE_CHK_EN flags accesses outside BASE..BASE+DEPTH*4-1.
//
// state | meaning
// IDLE  | req_ready high, waiting for mem_ren/mem_wen
// BUSY  | request latched, cnt counts down to the access edge
// RESP  | one-cycle rsp_valid pulse, then back to IDLE
module ysyx_23060332_dmem_resp #(
  parameter int          DATA_W  = 32,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 1,
  parameter logic [31:0] BASE    = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_ren,
  input  logic [31:0]       mem_raddr,
  input  logic              mem_wen,
  input  logic [31:0]       mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [7:0]        mem_wmask,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_err
);
  localparam int LANES = DATA_W / 8;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              op_wr;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  wmask_q;
  logic              err_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [31:0] req_addr;
  logic [31:0] off;
  logic        req_oor;
  logic        access;
  logic        unused_bits;

  // A collision services the write, so the write address wins.
  assign req_addr = mem_wen ? mem_waddr : mem_raddr;
  assign off      = req_addr - BASE;
  assign access   = (state == BUSY) && (cnt == 4'd0);

`ifdef YSYX_23060332_DMEM_RANGE_CHK_EN
  assign req_oor = (off >> (AW + 2)) != 32'd0;
`else
  assign req_oor = 1'b0;
`endif

  assign unused_bits = ^{off[31:AW+2], off[1:0], mem_wmask[7:LANES]};
  assign rsp_err     = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      mem_rdata <= '0;
      rsp_err_q <= 1'b0;
      op_wr     <= 1'b0;
      idx       <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_ren || mem_wen) begin
            op_wr     <= mem_wen;
            idx       <= off[AW+1:2];
            wdata_q   <= mem_wdata;
            wmask_q   <= mem_wmask[LANES-1:0];
            err_q     <= req_oor;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!op_wr) mem_rdata <= err_q ? DATA_W'(32'hDEAD_BEEF) : mem[idx];
            rsp_valid <= 1'b1;
            rsp_err_q <= err_q;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err_q <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array write lives outside the reset block; an async reset drops state to IDLE,
  // so an aborted write never reaches its access edge.
  always_ff @(posedge clk) begin
    if (access && op_wr && !err_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask_q[i]) mem[idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_dmem_resp.sv
// Scoreboard bench for ysyx_23060332_dmem_resp: two instances (LATENCY 1 and 4) share clock and reset.
module tb_ysyx_23060332_dmem_resp;
  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ren = '0;
  logic [1:0]  wen = '0;
  logic [31:0] raddr [2];
  logic [31:0] waddr [2];
  logic [31:0] wdata [2];
  logic [7:0]  wmask [2];
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_err;
  logic [31:0] mem_rdata [2];

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_23060332_dmem_resp #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .mem_ren(ren[0]), .mem_raddr(raddr[0]),
    .mem_wen(wen[0]), .mem_waddr(waddr[0]), .mem_wdata(wdata[0]), .mem_wmask(wmask[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
    .mem_rdata(mem_rdata[0]), .rsp_err(rsp_err[0])
  );

  ysyx_23060332_dmem_resp #(.LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n),
    .mem_ren(ren[1]), .mem_raddr(raddr[1]),
    .mem_wen(wen[1]), .mem_waddr(waddr[1]), .mem_wdata(wdata[1]), .mem_wmask(wmask[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
    .mem_rdata(mem_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int lat(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare(exp_t e, int d);
    chk({e.name, " rdata"}, mem_rdata[d], e.rdata);
    chk({e.name, " err"}, {31'b0, rsp_err[d]}, {31'b0, e.err});
    chk({e.name, " cycle"}, 32'(cyc), 32'(e.due));
  endtask

  // Monitor: pops one expectation per rsp_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid[0]) begin
      if (q0.size() == 0) chk("unexpected rsp dut0", 32'd1, 32'd0);
      else begin e = q0.pop_front(); compare(e, 0); end
    end
    if (rsp_valid[1]) begin
      if (q1.size() == 0) chk("unexpected rsp dut1", 32'd1, 32'd0);
      else begin e = q1.pop_front(); compare(e, 1); end
    end
  end

  // Drives one request when the DUT is ready; returns at the negedge after the accept edge.
  task automatic issue(string name, int d, bit r, bit w, logic [31:0] ra, logic [31:0] wa,
                       logic [31:0] wd, logic [7:0] wm, logic [31:0] exp_rd, bit exp_err);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready[d] && n < 64) begin @(negedge clk); n++; end
    if (!req_ready[d]) begin
      chk({name, " req_ready timeout"}, 32'd0, 32'd1);
      return;
    end
    ren[d] = r; wen[d] = w; raddr[d] = ra; waddr[d] = wa; wdata[d] = wd; wmask[d] = wm;
    if (!w) last_rd[d] = exp_rd;
    e.name  = name;
    e.rdata = last_rd[d];
    e.err   = exp_err;
    e.due   = cyc + 1 + lat(d);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    ren[d] = 1'b0; wen[d] = 1'b0;
    raddr[d] = 32'hFFFF_FFFF; waddr[d] = 32'hFFFF_FFFF; wdata[d] = 32'hFFFF_FFFF; wmask[d] = 8'hFF;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin @(negedge clk); n++; end
    if (q0.size() != 0 || q1.size() != 0)
      chk("response timeout", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic rd(string name, int d, logic [31:0] a, logic [31:0] exp_rd, bit exp_err);
    issue(name, d, 1'b1, 1'b0, a, 32'h0, 32'h0, 8'h0, exp_rd, exp_err);
  endtask

  task automatic wr(string name, int d, logic [31:0] a, logic [31:0] dat, logic [7:0] m, bit exp_err);
    issue(name, d, 1'b0, 1'b1, 32'h0, a, dat, m, 32'h0, exp_err);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      raddr[d] = '0; waddr[d] = '0; wdata[d] = '0; wmask[d] = '0; last_rd[d] = '0;
    end

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset req_ready dut%0d", d), {31'b0, req_ready[d]}, 32'd1);
      chk($sformatf("reset rsp_valid dut%0d", d), {31'b0, rsp_valid[d]}, 32'd0);
      chk($sformatf("reset rdata dut%0d", d), mem_rdata[d], 32'd0);
      chk($sformatf("reset rsp_err dut%0d", d), {31'b0, rsp_err[d]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset req_ready", {31'b0, req_ready[0]}, 32'd1);

    wr("w 0x10", 0, 32'h8000_0010, 32'h1234_5678, 8'h0F, 1'b0);
    rd("r 0x10", 0, 32'h8000_0010, 32'h1234_5678, 1'b0);
    wr("preload 0x20", 0, 32'h8000_0020, 32'hAABB_CCDD, 8'h0F, 1'b0);
    wr("mask5 0x20", 0, 32'h8000_0020, 32'h1122_3344, 8'h05, 1'b0);
    rd("r mask5", 0, 32'h8000_0020, 32'hAA22_CC44, 1'b0);
    wr("mask0 0x20", 0, 32'h8000_0020, 32'hFFFF_FFFF, 8'hF0, 1'b0);
    rd("r mask0", 0, 32'h8000_0020, 32'hAA22_CC44, 1'b0);
    issue("collision", 0, 1'b1, 1'b1, 32'h8000_0010, 32'h8000_0030, 32'h0000_0005, 8'h0F, 32'h0, 1'b0);
    rd("r collision", 0, 32'h8000_0030, 32'h0000_0005, 1'b0);
    rd("r byte-offset", 0, 32'h8000_0013, 32'h1234_5678, 1'b0);

    wr("l4 w 0x40", 1, 32'h8000_0040, 32'hCAFE_0040, 8'h0F, 1'b0);
    rd("l4 r 0x40", 1, 32'h8000_0040, 32'hCAFE_0040, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      chk($sformatf("l4 busy req_ready k%0d", k), {31'b0, req_ready[1]}, 32'd0);
      chk($sformatf("l4 rsp_valid k%0d", k), {31'b0, rsp_valid[1]}, (k == 4) ? 32'd1 : 32'd0);
      if (k < 4) @(negedge clk);
    end
    @(negedge clk);
    chk("l4 req_ready after resp", {31'b0, req_ready[1]}, 32'd1);

    drain();
    wr("l4 aborted w 0x40", 1, 32'h8000_0040, 32'h0BAD_0BAD, 8'h0F, 1'b0);
    rst_n = 1'b0;
    q1.delete();
    last_rd[0] = '0;
    last_rd[1] = '0;
    #1;
    chk("abort req_ready", {31'b0, req_ready[1]}, 32'd1);
    chk("abort rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
    chk("abort rdata", mem_rdata[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("l4 r after abort", 1, 32'h8000_0040, 32'hCAFE_0040, 1'b0);

    wr("w word0", 0, 32'h8000_0000, 32'h0000_A0A0, 8'h0F, 1'b0);
`ifdef YSYX_23060332_DMEM_RANGE_CHK_EN
    rd("r oor", 0, 32'h8000_1000, 32'hDEAD_BEEF, 1'b1);
    rd("r below base", 0, 32'h7FFF_FFFC, 32'hDEAD_BEEF, 1'b1);
    wr("w oor", 0, 32'h8000_1000, 32'h0000_0077, 8'h0F, 1'b1);
    rd("r word0 after oor w", 0, 32'h8000_0000, 32'h0000_A0A0, 1'b0);
`else
    rd("r alias", 0, 32'h8000_1000, 32'h0000_A0A0, 1'b0);
    wr("w alias", 0, 32'h8000_1000, 32'h0000_0077, 8'h0F, 1'b0);
    rd("r word0 after alias w", 0, 32'h8000_0000, 32'h0000_0077, 1'b0);
`endif

    drain();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
